// File: rtl/e1_crc4_pkg.sv
// rtl/e1_crc4_pkg.sv - shared constants and CRC-4 step function for the E1 CRC-4 checker
package e1_crc4_pkg;

  localparam logic [4:0] C_TS       = 5'd0;
  localparam logic [2:0] C_BITPOS   = 3'd0;
  localparam logic       C_FRAME_LSB = 1'b0;
  localparam int         SMF_FRAMES = 8;
  localparam int         SMF_FBITS  = $clog2(SMF_FRAMES);

  localparam logic [3:0] CRC_INIT = 4'h0;
  localparam logic [3:0] CRC_POLY = 4'h3;

  // MSB-first serial division step; poly carries the terms below x^4.
  function automatic logic [3:0] crc4_step(
    input logic [3:0] crc,
    input logic [3:0] poly,
    input logic       din
  );
    logic fb;
    fb = crc[3] ^ din;
    return {crc[2:0], 1'b0} ^ (fb ? poly : 4'h0);
  endfunction

endpackage

// File: rtl/e1_crc4.sv
// rtl/e1_crc4.sv - serial CRC-4 engine; in_first restarts from INIT on that beat
module e1_crc4
  import e1_crc4_pkg::*;
#(
  parameter logic [3:0] INIT = CRC_INIT,
  parameter logic [3:0] POLY = CRC_POLY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_first,
  output logic [3:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= INIT;
    end else if (in_valid) begin
      crc <= crc4_step(in_first ? INIT : crc, POLY, in_bit);
    end
  end

endmodule

// File: rtl/e1_crc4_check.sv
// rtl/e1_crc4_check.sv - E1 receive CRC-4 verifier: per-SMF verdicts and saturating error count
module e1_crc4_check
  import e1_crc4_pkg::*;
#(
  parameter logic [3:0] INIT  = CRC_INIT,
  parameter logic [3:0] POLY  = CRC_POLY,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic [4:0]       in_ts,
  input  logic [2:0]       in_bitpos,
  input  logic [3:0]       in_frame,
  input  logic             in_mf_sync,
  output logic             out_valid,
  output logic             out_err,
  output logic             out_smf,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  logic       accept;
  logic       c_pos;
  logic [1:0] c_idx;
  logic       smf_start;
  logic       c4_pos;
  logic       eng_bit;
  logic [3:0] eng_crc;
  logic       mismatch;

  logic       armed;
  logic       ref_ok;
  logic       ref_smf;
  logic [3:0] crc_ref;
  logic [3:0] rx_c;

  assign accept    = in_valid & in_mf_sync;
  assign c_pos     = (in_ts == C_TS) && (in_bitpos == C_BITPOS) && (in_frame[0] == C_FRAME_LSB);
  assign c_idx     = in_frame[2:1];
  assign smf_start = c_pos && (in_frame[SMF_FBITS-1:0] == '0);
  assign c4_pos    = c_pos && (c_idx == 2'd3);
  assign eng_bit   = in_bit & ~c_pos;
  assign mismatch  = ({rx_c[3:1], in_bit} != crc_ref);

  e1_crc4 #(
    .INIT (INIT),
    .POLY (POLY)
  ) u_crc (
    .clk      (clk),
    .rst      (rst),
    .in_bit   (eng_bit),
    .in_valid (accept),
    .in_first (smf_start),
    .crc      (eng_crc)
  );

  // eng_crc still holds the whole previous SMF on the SMF-start beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed     <= 1'b0;
      ref_ok    <= 1'b0;
      ref_smf   <= 1'b0;
      crc_ref   <= 4'h0;
      rx_c      <= 4'h0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_smf   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        if (!in_mf_sync) begin
          armed  <= 1'b0;
          ref_ok <= 1'b0;
          rx_c   <= 4'h0;
        end else begin
          if (smf_start) begin
            if (armed) begin
              crc_ref <= eng_crc;
              ref_ok  <= 1'b1;
              ref_smf <= ~in_frame[3];
            end
            armed <= 1'b1;
          end
          if (c_pos) begin
            rx_c[2'd3 - c_idx] <= in_bit;
          end
          if (c4_pos && ref_ok) begin
            out_valid <= 1'b1;
            out_err   <= mismatch;
            out_smf   <= ref_smf;
            ref_ok    <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_e1_crc4_check.sv
// tb/tb_e1_crc4_check.sv - directed bench for e1_crc4_check
module tb_e1_crc4_check;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_ts = '0;
  logic [2:0]  in_bitpos = '0;
  logic [3:0]  in_frame = '0;
  logic        in_mf_sync = 1'b0;
  logic        err_clr = 1'b0;
  logic        out_valid, out_err, out_smf;
  logic [15:0] err_cnt;
  logic        out_valid2, out_err2, out_smf2;
  logic [1:0]  err_cnt2;

  int total = 0;
  int bad = 0;
  bit pay [2048];
  bit half = 1'b0;
  bit clr_arm = 1'b0;
  logic [3:0] last_crc = 4'h0;
  bit vq_err [$];
  bit vq_smf [$];

  e1_crc4_check dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ts(in_ts),
    .in_bitpos(in_bitpos), .in_frame(in_frame), .in_mf_sync(in_mf_sync),
    .out_valid(out_valid), .out_err(out_err), .out_smf(out_smf),
    .err_cnt(err_cnt), .err_clr(err_clr)
  );

  e1_crc4_check #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ts(in_ts),
    .in_bitpos(in_bitpos), .in_frame(in_frame), .in_mf_sync(in_mf_sync),
    .out_valid(out_valid2), .out_err(out_err2), .out_smf(out_smf2),
    .err_cnt(err_cnt2), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Long division of the masked SMF (C slots at bit 0, 512, 1024, 1536) times x^4.
  function automatic logic [3:0] model_crc();
    logic [4:0] r;
    bit b;
    r = '0;
    for (int i = 0; i < 2052; i++) begin
      b = (i < 2048 && (i % 512) != 0) ? pay[i] : 1'b0;
      r = {r[3:0], b};
      if (r[4]) r = r ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  task automatic beat(input bit v, input bit b, input logic [4:0] ts,
                      input logic [2:0] bp, input logic [3:0] fr, input bit sync);
    in_valid = v; in_bit = b; in_ts = ts; in_bitpos = bp; in_frame = fr; in_mf_sync = sync;
    @(posedge clk);
    #1;
    if (out_valid) begin
      vq_err.push_back(out_err);
      vq_smf.push_back(out_smf);
    end
    err_clr = clr_arm & out_valid & out_err;
  endtask

  task automatic send_smf(input logic [3:0] c, input bit rnd, input int set_idx,
                          input int flip_idx, input int drop_at, input int rst_at);
    int f;
    bit b;
    for (int i = 0; i < 2048; i++) begin
      pay[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == set_idx) pay[i] = 1'b1;
    end
    last_crc = model_crc();
    for (int i = 0; i < 2048; i++) begin
      if (i == rst_at) begin
        chk("pre_rst_out_err", out_err, 1'b1);
        chk("pre_rst_err_cnt", err_cnt, 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_err", out_err, 1'b0);
        chk("rst_out_smf", out_smf, 1'b0);
        chk("rst_err_cnt", err_cnt, 16'd0);
        chk("rst_err_cnt2", err_cnt2, 2'd0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      if (rnd && (i % 97) == 0) beat(1'b0, 1'b1, 5'd0, 3'd0, 4'd0, 1'b1);
      f = i / 256;
      b = ((i % 512) == 0) ? c[3 - i / 512] : pay[i];
      if (i == flip_idx) b = ~b;
      beat(1'b1, b, 5'((i % 256) / 8), 3'(i % 8), {half, 3'(f)}, i != drop_at);
    end
    half = ~half;
  endtask

  function automatic logic [31:0] err_mask();
    logic [31:0] m;
    m = '0;
    foreach (vq_err[i]) m[i] = vq_err[i];
    return m;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_err", out_err, 1'b0);
    chk("reset_out_smf", out_smf, 1'b0);
    chk("reset_err_cnt", err_cnt, 16'd0);
    rst = 1'b0;

    // all-zero traffic: no verdict in first SMF, then verdicts for SMF 0 and 1
    send_smf(4'h0, 1'b0, -1, -1, -1, -1);
    chk("zero_first_smf_nv", vq_err.size(), 0);
    send_smf(4'h0, 1'b0, -1, -1, -1, -1);
    send_smf(4'h0, 1'b0, -1, -1, -1, -1);
    chk("zero_nv", vq_err.size(), 2);
    chk("zero_err_mask", err_mask(), 0);
    chk("zero_smf0", vq_smf[0], 1'b0);
    chk("zero_smf1", vq_smf[1], 1'b1);
    vq_err.delete(); vq_smf.delete();

    // C bits 1000 against an all-zero SMF
    send_smf(4'h0, 1'b0, -1, -1, -1, -1);
    send_smf(4'h8, 1'b0, -1, -1, -1, -1);
    chk("c1000_nv", vq_err.size(), 2);
    chk("c1000_err_mask", err_mask(), 32'b10);
    chk("c1000_smf", vq_smf[1], 1'b1);
    chk("c1000_err_cnt", err_cnt, 16'd1);
    vq_err.delete(); vq_smf.delete();

    // random payload with correct C bits, then one corrupted payload bit
    repeat (4) send_smf(last_crc, 1'b1, -1, -1, -1, -1);
    send_smf(last_crc, 1'b1, -1, 1000, -1, -1);
    send_smf(last_crc, 1'b1, -1, -1, -1, -1);
    send_smf(last_crc, 1'b1, -1, -1, -1, -1);
    chk("rand_nv", vq_err.size(), 7);
    chk("rand_err_mask", err_mask(), 32'b0100000);
    chk("rand_err_cnt", err_cnt, 16'd2);
    vq_err.delete(); vq_smf.delete();

    // last bit set gives CRC x^4 mod G = 0011; C bits carrying it must be masked
    send_smf(last_crc, 1'b0, 2047, -1, -1, -1);
    send_smf(4'h3, 1'b0, -1, -1, -1, -1);
    send_smf(4'h0, 1'b0, -1, -1, -1, -1);
    chk("mask_nv", vq_err.size(), 3);
    chk("mask_err_mask", err_mask(), 0);
    vq_err.delete(); vq_smf.delete();

    // one-beat sync drop in frame 3 loses two verdicts
    send_smf(4'h0, 1'b0, -1, -1, 3 * 256 + 10, -1);
    send_smf(4'h0, 1'b0, -1, -1, -1, -1);
    chk("drop_nv_early", vq_err.size(), 0);
    send_smf(4'h0, 1'b0, -1, -1, -1, -1);
    send_smf(4'h0, 1'b0, -1, -1, -1, -1);
    chk("drop_nv", vq_err.size(), 2);
    chk("drop_err_mask", err_mask(), 0);
    chk("drop_smf0", vq_smf[0], 1'b0);
    chk("drop_smf1", vq_smf[1], 1'b1);
    vq_err.delete(); vq_smf.delete();

    // three more errors: 16-bit counter reaches 5, 2-bit counter saturates at 3
    repeat (3) send_smf(4'h8, 1'b0, -1, -1, -1, -1);
    chk("sat_err_cnt", err_cnt, 16'd5);
    chk("sat_err_cnt2", err_cnt2, 2'd3);
    clr_arm = 1'b1;
    send_smf(4'h8, 1'b0, -1, -1, -1, -1);
    clr_arm = 1'b0;
    chk("clr_err_cnt", err_cnt, 16'd0);
    chk("clr_err_cnt2", err_cnt2, 2'd0);
    chk("clr_out_err_held", out_err, 1'b1);
    send_smf(4'h8, 1'b0, -1, -1, -1, -1);
    vq_err.delete(); vq_smf.delete();

    // async reset mid-SMF, then recovery
    send_smf(4'h0, 1'b0, -1, -1, -1, 1000);
    send_smf(4'h0, 1'b0, -1, -1, -1, -1);
    send_smf(4'h0, 1'b0, -1, -1, -1, -1);
    chk("post_rst_nv", vq_err.size(), 1);
    chk("post_rst_err_mask", err_mask(), 0);
    chk("post_rst_err_cnt", err_cnt, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e1_crc4_check.md
# e1_crc4_check

Receive-side CRC-4 verifier for E1 multiframes. Consumes the aligned receive bit stream from the E1 framer, with timeslot, bit and frame position tags. Computes CRC-4 over each sub-multiframe (SMF) with the C-bit positions forced to zero, then compares the result against C1..C4 carried in the following SMF. Emits one verdict per checked SMF and keeps a saturating error count for the E-bit / status logic.

## Interface
Parameters:
- `INIT`, 4'h0, CRC register preset at each SMF start.
- `POLY`, 4'h3, feedback polynomial (x^4+x+1).
- `CNT_W`, 16, width of the error counter.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_bit`  in  1  received bit.
- `in_valid`  in  1  `in_bit` and its tags are valid this cycle.
- `in_ts`  in  5  timeslot 0..31.
- `in_bitpos`  in  3  bit within timeslot; 0 is first on the wire (MSB).
- `in_frame`  in  4  frame index 0..15 within the CRC multiframe.
- `in_mf_sync`  in  1  framer holds CRC multiframe alignment; tags are trustworthy.
- `out_valid`  out  1  one-cycle verdict strobe.
- `out_err`  out  1  qualified by `out_valid`; 1 = CRC mismatch.
- `out_smf`  out  1  qualified by `out_valid`; SMF checked (0 = frames 0-7, 1 = frames 8-15).
- `err_cnt`  out  CNT_W  saturating mismatch count.
- `err_clr`  in  1  synchronous clear of `err_cnt`.

## Operation
- C-bit position: `in_ts==0`, `in_bitpos==0`, `in_frame[0]==0`. Ci index = `in_frame[2:1]`, so C1 is in frame 0/8 and C4 is in frame 6/14.
- SMF start: C1 position with `in_frame[2:0]==0`. It drives `in_first` of the CRC engine.
- CRC engine input is `in_bit`, forced to 0 at C-bit positions. The engine advances only when `in_valid & in_mf_sync`.
- At each SMF start (accepted beat):
  - If `armed`, latch the engine output into `crc_ref`, set `ref_ok`, and latch `ref_smf = ~in_frame[3]`.
  - Set `armed`.
- At each C-bit position: store `in_bit` into `rx_c[3 - in_frame[2:1]]`.
- At the C4 position with `ref_ok`:
  - Compare `{rx_c[3:1], in_bit}` with `crc_ref`.
  - Next cycle: `out_valid=1`, `out_err=(mismatch)`, `out_smf=ref_smf`.
  - Clear `ref_ok`.
- State flags:
  - `armed`: a complete SMF has been fed since sync.
  - `ref_ok`: a reference is pending.
- `in_mf_sync` low: clears `armed`, `ref_ok` and `rx_c`. No verdicts are issued. The first verdict after re-sync covers the first full SMF seen under sync.
- `err_cnt`:
  - Increments on `out_valid & out_err`, saturating at all-ones.
  - `err_clr` wins over a simultaneous increment; the result is 0.
- Beats with `in_valid=0` change nothing.

## Timing
- Reset values: `out_valid=0`, `out_err=0`, `out_smf=0`, `err_cnt=0`, `armed=0`, `ref_ok=0`, `crc_ref=0`, `rx_c=0`, CRC state = `INIT`.
- Verdict latency is 1 cycle after the accepted C4 beat. Verdict outputs hold their value between strobes; `out_valid` is a single cycle.
- `crc_ref` is sampled from the engine register during the SMF-start beat, before that beat's update. This works because the engine output lags its input by 1 cycle and therefore still holds the full previous-SMF CRC.
- Rate: at most one verdict per 8 frames (2048 accepted beats). Back-to-back `in_valid` every cycle is supported.
- Async `rst` mid-SMF aborts the check; no verdict is issued for the broken SMF.
- Tag jumps, i.e. a framer realignment without dropping sync, are not detected here. The framer must drop `in_mf_sync` for at least one accepted beat.

## Structure
- Shared package holds:
  - C-bit position decode constants (TS0, bit 0, even frame).
  - `SMF_FRAMES=8`.
  - CRC defaults `INIT` and `POLY`.
- One sub-module: `e1_crc4`, the existing serial CRC-4 engine. It is instantiated unchanged with `in_first` = SMF start and `in_valid` = accepted beat.
- Top level contains the position decode, `rx_c` and `crc_ref` capture, the flag logic, the verdict register and the counter.

## Test plan
- All-zero payload, C bits 0000, sync high for 3 SMFs → verdicts on SMFs 1 and 2 (`out_smf` 0 then 1), `out_err=0`. No verdict during the first SMF.
- All-zero SMF followed by C bits 1000 → `out_err=1`, `err_cnt=1`.
- Random payload from the reference model with correct C bits across 32 SMFs → 31 verdicts, all `err=0`. Flip one payload bit (non-C) → exactly that SMF's verdict errs.
- Set a payload C-bit position to 1 versus 0 → no verdict change, proving C-bit masking.
- Drop `in_mf_sync` mid-SMF for 1 beat → no verdict for the two affected SMFs, then verdicts resume. Async `rst` mid-SMF → all outputs 0 within the same cycle.
- With `CNT_W=2`, force 5 errors → `err_cnt` saturates at 3. `err_clr` coincident with an error → 0.
